// File: rtl/bcd_up_counter_pkg.sv
// Shared constants, types and the one-digit increment rule used by the
// BCD up-counter and its digit cells.
package bcd_up_counter_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] digit_t;

    localparam digit_t BCD_MAX  = 4'd9;
    localparam digit_t BCD_ZERO = 4'd0;

    typedef struct packed {
        logic   carry;
        digit_t value;
    } digit_inc_t;

    // Codes 10..15 can only arrive by load; they roll over exactly like 9.
    function automatic digit_inc_t digit_inc(input digit_t value);
        digit_inc_t r;
        r.carry = (value >= BCD_MAX);
        r.value = r.carry ? BCD_ZERO : digit_t'(value + digit_t'(1));
        return r;
    endfunction

endpackage

// File: rtl/bcd_up_digit.sv
// One BCD digit cell: register, parallel load and a single-digit incrementer
// producing the rollover carry for the next cell.
module bcd_up_digit
    import bcd_up_counter_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   ei,
    input  logic   ld,
    input  digit_t d,
    output digit_t q,
    output logic   co,
    output logic   nine
);

    digit_inc_t inc;

    assign inc = digit_inc(q);

    // NOTE: state is written with non-blocking assignments so every cell
    // samples its neighbours' pre-edge values, keeping the ripple chain exact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= BCD_ZERO;
        end else if (ld) begin
            q <= d;
        end else if (ei) begin
            q <= inc.value;
        end
    end

    // co steps the next digit (non-BCD codes roll like 9); nine is a true 9.
    assign co   = ei & inc.carry & ~ld;
    assign nine = (q == BCD_MAX);

endmodule

// File: rtl/bcd_up_counter.sv
// Multi-digit decimal up counter built as a ripple chain of BCD digit cells,
// with parallel load and a combinational carry-out for cascading.
module bcd_up_counter
    import bcd_up_counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ei,
    input  logic                    ld,
    input  logic [BCD_W*DIGITS-1:0] d,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                    eu
);

    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] nine;

    assign carry[0] = ei;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_up_digit u_digit (
                .clock (clock),
                .reset (reset),
                .ei    (carry[i]),
                .ld    (ld),
                .d     (d[BCD_W*i +: BCD_W]),
                .q     (q[BCD_W*i +: BCD_W]),
                .co    (carry[i+1]),
                .nine  (nine[i])
            );
        end
    endgenerate

    // Carry out only when the whole counter wraps and every digit is a real 9,
    // so a loaded non-BCD code never bumps the next instance.
    assign eu = carry[DIGITS] & (&nine);

endmodule

// File: tb/tb_bcd_up_counter.sv
// Scoreboard bench for bcd_up_counter: a 2-digit instance plus a cascade of two
// 1-digit instances, checked against a digit-rule reference model.
module tb_bcd_up_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ei = 1'b0, ld = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q;
    logic       eu;

    logic       ei_c = 1'b0, ld_c = 1'b0;
    logic [7:0] d_c = 8'h00;
    logic [3:0] q_lo, q_hi;
    logic       eu_lo, eu_hi;

    always #5 clock = ~clock;

    bcd_up_counter #(.DIGITS(2)) dut (
        .clock (clock), .reset (reset), .ei (ei), .ld (ld), .d (d), .q (q), .eu (eu)
    );

    bcd_up_counter #(.DIGITS(1)) u_lo (
        .clock (clock), .reset (reset), .ei (ei_c), .ld (ld_c), .d (d_c[3:0]),
        .q (q_lo), .eu (eu_lo)
    );

    bcd_up_counter #(.DIGITS(1)) u_hi (
        .clock (clock), .reset (reset), .ei (eu_lo), .ld (ld_c), .d (d_c[7:4]),
        .q (q_hi), .eu (eu_hi)
    );

    typedef struct {
        logic       cas;
        logic [7:0] q;
        logic       eu;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         pulses = 0;
    logic [7:0] m_main = 8'h00;
    logic [7:0] m_cas  = 8'h00;

    // Decimal successor from the digit rules: a digit below 9 absorbs the
    // increment; a 9 (or any non-BCD code) becomes 0 and passes it upward.
    function automatic logic [7:0] bcd_succ(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < 2; i++) begin
            if (r[4*i +: 4] < 4'd9) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                return r;
            end
            r[4*i +: 4] = 4'd0;
        end
        return r;
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] v, input logic l,
                                              input logic e, input logic [7:0] dv);
        if (l) return dv;
        if (e) return bcd_succ(v);
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle on the selected counter, publish what it must show now,
    // then advance the reference model across the coming edge.
    task automatic step(input logic cas, input logic l, input logic e,
                        input logic [7:0] dv, input logic r, input string name);
        exp_t x;
        @(negedge clock);
        if (cas) begin
            ld_c = l; ei_c = e; d_c = dv;
            ld = 1'b0; ei = 1'b0; d = 8'h00;
        end else begin
            ld = l; ei = e; d = dv;
            ld_c = 1'b0; ei_c = 1'b0; d_c = 8'h00;
        end
        #1 reset = r;
        if (r) begin
            m_main = 8'h00;
            m_cas  = 8'h00;
        end
        x.cas  = cas;
        x.q    = cas ? m_cas : m_main;
        x.eu   = e & ~l & (x.q == 8'h99);
        x.name = name;
        sb.push_back(x);
        if (!r) begin
            if (cas) m_cas = model_next(m_cas, l, e, dv);
            else     m_main = model_next(m_main, l, e, dv);
        end
    endtask

    // Monitor: well clear of the posedge, compare whatever has been published.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #4;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.cas) begin
                    check({e.name, " q"}, {q_hi, q_lo}, e.q);
                    check({e.name, " eu"}, {7'd0, eu_hi}, {7'd0, e.eu});
                    if (eu_hi === 1'b1) pulses++;
                end else begin
                    check({e.name, " q"}, q, e.q);
                    check({e.name, " eu"}, {7'd0, eu}, {7'd0, e.eu});
                end
            end
        end
    end

    initial begin
        logic [7:0] rd;

        step(0, 0, 0, 8'h00, 1, "reset");
        step(0, 1, 0, 8'h37, 0, "load 37");
        step(0, 0, 1, 8'h00, 1, "async reset");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0, "idle after reset");

        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h00, 0, "count");
        step(0, 0, 0, 8'h00, 0, "count end");

        step(0, 1, 0, 8'h98, 0, "load 98");
        step(0, 0, 1, 8'h00, 0, "wrap 98");
        step(0, 0, 1, 8'h00, 0, "wrap 99");
        step(0, 0, 0, 8'h00, 0, "wrap 00");

        step(0, 1, 0, 8'h45, 0, "load 45");
        step(0, 1, 1, 8'h72, 0, "ld over ei");
        step(0, 0, 1, 8'h00, 0, "count 72");
        step(0, 0, 0, 8'h00, 0, "hold 73");

        step(0, 1, 0, 8'h99, 0, "load 99");
        step(0, 1, 1, 8'h10, 0, "ld gates eu");
        step(0, 0, 0, 8'h00, 0, "after ld 10");

        step(0, 1, 0, 8'h19, 0, "load 19");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 0, "hold 19");
        step(0, 1, 0, 8'h1C, 0, "load 1C");
        step(0, 0, 1, 8'h00, 0, "non-bcd 1C");
        step(0, 0, 0, 8'h00, 0, "non-bcd 20");

        step(0, 1, 0, 8'h9C, 0, "load 9C");
        step(0, 0, 1, 8'h00, 0, "non-bcd 9C");
        step(0, 1, 0, 8'hF9, 0, "load F9");
        step(0, 0, 1, 8'h00, 0, "non-bcd F9");
        step(0, 0, 0, 8'h00, 0, "non-bcd 00");

        step(1, 1, 0, 8'h09, 0, "cascade load");
        for (int i = 0; i < 91; i++) step(1, 0, 1, 8'h00, 0, "cascade count");
        step(1, 0, 0, 8'h00, 0, "cascade end");

        for (int k = 0; k < 300; k++) begin
            rd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 15) == 0) rd[3:0] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 15) == 0) rd[7:4] = 4'($urandom_range(10, 15));
            step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, rd,
                 $urandom_range(0, 60) == 0, "random");
        end

        repeat (2) @(negedge clock);
        check("scoreboard drained", 8'(sb.size()), 8'd0);
        check("cascade eu pulses", 8'(pulses), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
